fetch_pipe_ctrl: RTL and testbench

- Receiving end of the hazard-control interface: consumes PC-stall, IF/ID-stall and bubble requests from the hazard unit, plus branch/jump redirects from EX.
- Owns the PC, the instruction-memory fetch handshake, the IF/ID instruction register (ir1) and the ID/EX instruction register (ir2).
- Guarantees that stalled instructions are neither lost nor duplicated, and that bubbles enter ID/EX as a NOP encoding.

---
 rtl/fetch_pipe_ctrl_if.sv | 25 ++
 rtl/fetch_pipe_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fetch_pipe_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pipe_ctrl_if.sv
// Instruction-memory fetch handshake between the fetch controller and imem.
// The fetch controller drives the request and address, and memory returns a
// single-cycle ack with the instruction word.
interface fetch_pipe_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req_o;
    logic [PC_WIDTH-1:0] imem_addr_o;
    logic                imem_ack_i;
    logic [31:0]         imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );
endinterface

// File: rtl/fetch_pipe_ctrl.sv
// Fetch-side pipeline control. This block owns the PC, the imem fetch
// handshake, and the IF/ID (ir1) and ID/EX (ir2) instruction registers. It
// applies the stall and bubble requests from the hazard unit and the redirects
// from EX. A stalled instruction is neither lost nor duplicated, and a bubble
// always enters ID/EX as NOP_INSTR.
module fetch_pipe_ctrl #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  PC_STEP   = 4,
    parameter logic [31:0]         NOP_INSTR = 32'hF000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_pc_i,
    input  logic                stall_ifid_i,
    input  logic                bubble_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    fetch_pipe_ctrl_if.master   imem,
    output logic [31:0]         if_ir_o,
    output logic [PC_WIDTH-1:0] if_pc_o,
    output logic                if_valid_o,
    output logic [31:0]         ex_ir_o,
    output logic [PC_WIDTH-1:0] ex_pc_o
);

    typedef enum logic [1:0] {
        S_IDLE,  // no request outstanding, waiting for the PC stall to lift
        S_REQ,   // request outstanding at imem_addr_o
        S_HOLD,  // word fetched but IF/ID is stalled, so it waits in fetch_buf
        S_DROP   // redirected while a request was in flight; its data is discarded
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic                addr_load;
    logic [31:0]         fetch_buf;
    logic                buf_load;
    logic                deliver;
    logic [31:0]         fetch_word;
    logic                adv;
    logic [PC_WIDTH-1:0] pc_next;

    assign adv     = !stall_pc_i && !stall_ifid_i;
    assign pc_next = pc_q + PC_WIDTH'(PC_STEP);

    // State register.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic, plus the per-cycle delivery, buffer and address decisions.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        deliver    = 1'b0;
        buf_load   = 1'b0;
        addr_load  = 1'b0;
        addr_d     = pc_q;
        fetch_word = (state_q == S_HOLD) ? fetch_buf : imem.imem_data_i;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    state_d   = S_REQ;
                    addr_load = 1'b1;
                    addr_d    = redirect_pc_i;
                end else if (!stall_pc_i) begin
                    state_d   = S_REQ;
                    addr_load = 1'b1;
                end
            end
            S_REQ: begin
                if (redirect_i) begin
                    if (imem.imem_ack_i) begin
                        addr_load = 1'b1;
                        addr_d    = redirect_pc_i;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem.imem_ack_i) begin
                    if (adv) begin
                        deliver   = 1'b1;
                        addr_load = 1'b1;
                        addr_d    = pc_next;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    state_d   = S_REQ;
                    addr_load = 1'b1;
                    addr_d    = redirect_pc_i;
                end else if (adv) begin
                    deliver   = 1'b1;
                    state_d   = S_REQ;
                    addr_load = 1'b1;
                    addr_d    = pc_next;
                end
            end
            S_DROP: begin
                // The old request completes and its data is thrown away. The PC
                // already holds the redirect target, unless a newer redirect
                // arrives in this same cycle.
                if (imem.imem_ack_i) begin
                    state_d   = S_REQ;
                    addr_load = 1'b1;
                    addr_d    = redirect_i ? redirect_pc_i : pc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: a request is outstanding in REQ and in DROP.
    always_comb begin
        imem.imem_req_o = (state_q == S_REQ) || (state_q == S_DROP);
    end

    assign imem.imem_addr_o = addr_q;

    // PC and fetch address: a redirect wins, and a delivered word advances the PC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q   <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            if (redirect_i)   pc_q <= redirect_pc_i;
            else if (deliver) pc_q <= pc_next;
            if (addr_load)    addr_q <= addr_d;
        end
    end

    // Holding buffer for a word whose ack arrived while the pipe was stalled.
    // NOTE: this buffer is reset even though it is only read after being
    // written, so that reset leaves no X values in simulation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         fetch_buf <= NOP_INSTR;
        else if (buf_load) fetch_buf <= imem.imem_data_i;
    end

    // IF/ID register (ir1): load on delivery, empty on redirect or an idle advance, hold on stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_ir_o    <= NOP_INSTR;
            if_pc_o    <= '0;
            if_valid_o <= 1'b0;
        end else if (redirect_i) begin
            if_ir_o    <= NOP_INSTR;
            if_valid_o <= 1'b0;
        end else if (deliver) begin
            if_ir_o    <= fetch_word;
            if_pc_o    <= addr_q;
            if_valid_o <= 1'b1;
        end else if (adv) begin
            if_ir_o    <= NOP_INSTR;
            if_valid_o <= 1'b0;
        end
    end

    // ID/EX register (ir2): insert a NOP on redirect, bubble or PC stall; hold
    // on an IF/ID stall; otherwise copy IF/ID.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_ir_o <= NOP_INSTR;
            ex_pc_o <= '0;
        end else if (redirect_i || bubble_i || stall_pc_i) begin
            ex_ir_o <= NOP_INSTR;
        end else if (!stall_ifid_i) begin
            ex_ir_o <= if_ir_o;
            ex_pc_o <= if_pc_o;
        end
    end

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed, table-driven bench for fetch_pipe_ctrl. Each record holds the
// inputs for one clock cycle and the outputs expected just after that edge.
// Hand-written sequences cover asynchronous reset in the middle of REQ and HOLD.
module tb_fetch_pipe_ctrl;

    localparam logic [31:0] N = 32'hF000_0000;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_pc_i = 1'b0, stall_ifid_i = 1'b0, bubble_i = 1'b0, redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] if_ir_o, if_pc_o, ex_ir_o, ex_pc_o;
    logic        if_valid_o;

    int errors = 0;
    int checks = 0;

    fetch_pipe_ctrl_if #(.PC_WIDTH(32)) bus ();

    fetch_pipe_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_pc_i    (stall_pc_i),
        .stall_ifid_i  (stall_ifid_i),
        .bubble_i      (bubble_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (bus),
        .if_ir_o       (if_ir_o),
        .if_pc_o       (if_pc_o),
        .if_valid_o    (if_valid_o),
        .ex_ir_o       (ex_ir_o),
        .ex_pc_o       (ex_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic sp, si, bb, rd;
        logic [31:0] rpc;
        logic ack;
        logic [31:0] data;
        logic req;
        logic [31:0] addr, if_ir, if_pc;
        logic if_v;
        logic [31:0] ex_ir, ex_pc;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then return 1 time unit after the rising edge.
    task automatic step(input logic sp, si, bb, rd, input logic [31:0] rpc,
                        input logic ack, input logic [31:0] data);
        @(negedge clk_i);
        stall_pc_i = sp; stall_ifid_i = si; bubble_i = bb; redirect_i = rd;
        redirect_pc_i = rpc; bus.imem_ack_i = ack; bus.imem_data_i = data;
        @(posedge clk_i);
        #1;
        bus.imem_ack_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " req"},    {31'd0, bus.imem_req_o}, 32'd0);
        check({tag, " addr"},   bus.imem_addr_o, 32'd0);
        check({tag, " if_ir"},  if_ir_o, N);
        check({tag, " if_v"},   {31'd0, if_valid_o}, 32'd0);
        check({tag, " if_pc"},  if_pc_o, 32'd0);
        check({tag, " ex_ir"},  ex_ir_o, N);
        check({tag, " ex_pc"},  ex_pc_o, 32'd0);
    endtask

    initial begin
        bus.imem_ack_i  = 1'b0;
        bus.imem_data_i = '0;

        //            sp si bb rd rpc            ack data           req addr           if_ir          if_pc          if_v ex_ir          ex_pc
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        O, 32'h0,         I, 32'h0,         N,             32'h0,         O,   N,             32'h0});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        I, 32'h11,        I, 32'h4,         32'h11,        32'h0,         I,   N,             32'h0});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        I, 32'h22,        I, 32'h8,         32'h22,        32'h4,         I,   32'h11,        32'h0});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        I, 32'h33,        I, 32'hC,         32'h33,        32'h8,         I,   32'h22,        32'h4});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        I, 32'h12345678,  I, 32'h10,        32'h12345678,  32'hC,         I,   32'h33,        32'h8});
        vq.push_back(vec_t'{I, O, I, O, 32'h0,        O, 32'h0,         I, 32'h10,        32'h12345678,  32'hC,         I,   N,             32'h8});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        O, 32'h0,         I, 32'h10,        N,             32'hC,         O,   32'h12345678,  32'hC});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        O, 32'h0,         I, 32'h10,        N,             32'hC,         O,   N,             32'hC});
        vq.push_back(vec_t'{I, O, O, O, 32'h0,        I, 32'h55,        O, 32'h10,        N,             32'hC,         O,   N,             32'hC});
        vq.push_back(vec_t'{I, O, O, O, 32'h0,        O, 32'h0,         O, 32'h10,        N,             32'hC,         O,   N,             32'hC});
        vq.push_back(vec_t'{I, O, O, O, 32'h0,        O, 32'h0,         O, 32'h10,        N,             32'hC,         O,   N,             32'hC});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        O, 32'h0,         I, 32'h14,        32'h55,        32'h10,        I,   N,             32'hC});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        O, 32'h0,         I, 32'h14,        N,             32'h10,        O,   32'h55,        32'h10});
        vq.push_back(vec_t'{O, I, O, O, 32'h0,        I, 32'h66,        O, 32'h14,        N,             32'h10,        O,   32'h55,        32'h10});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        O, 32'h0,         I, 32'h18,        32'h66,        32'h14,        I,   N,             32'h10});
        vq.push_back(vec_t'{O, O, O, I, 32'h40,       O, 32'h0,         I, 32'h18,        N,             32'h14,        O,   N,             32'h10});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        O, 32'h0,         I, 32'h18,        N,             32'h14,        O,   N,             32'h14});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        O, 32'h0,         I, 32'h18,        N,             32'h14,        O,   N,             32'h14});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        I, 32'hDEADBEEF,  I, 32'h40,        N,             32'h14,        O,   N,             32'h14});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        I, 32'h77,        I, 32'h44,        32'h77,        32'h40,        I,   N,             32'h14});
        vq.push_back(vec_t'{O, O, I, I, 32'h80,       I, 32'h88,        I, 32'h80,        N,             32'h40,        O,   N,             32'h14});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        I, 32'h99,        I, 32'h84,        32'h99,        32'h80,        I,   N,             32'h40});
        vq.push_back(vec_t'{O, O, O, I, 32'hFFFFFFFC, I, 32'hAA,        I, 32'hFFFFFFFC,  N,             32'h80,        O,   N,             32'h40});
        vq.push_back(vec_t'{O, O, O, O, 32'h0,        I, 32'hAB,        I, 32'h0,         32'hAB,        32'hFFFFFFFC,  I,   N,             32'h80});

        #12;
        check_reset_state("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].sp, vq[i].si, vq[i].bb, vq[i].rd, vq[i].rpc, vq[i].ack, vq[i].data);
            check($sformatf("v%0d req", i),   {31'd0, bus.imem_req_o}, {31'd0, vq[i].req});
            check($sformatf("v%0d addr", i),  bus.imem_addr_o, vq[i].addr);
            check($sformatf("v%0d if_ir", i), if_ir_o, vq[i].if_ir);
            check($sformatf("v%0d if_pc", i), if_pc_o, vq[i].if_pc);
            check($sformatf("v%0d if_v", i),  {31'd0, if_valid_o}, {31'd0, vq[i].if_v});
            check($sformatf("v%0d ex_ir", i), ex_ir_o, vq[i].ex_ir);
            check($sformatf("v%0d ex_pc", i), ex_pc_o, vq[i].ex_pc);
        end

        // Reset asserted while a request is outstanding at a nonzero address.
        step(O, O, O, O, 32'h0, I, 32'hC1);
        check("preA addr", bus.imem_addr_o, 32'h4);
        check("preA if_ir", if_ir_o, 32'hC1);
        #2 rst_i = 1'b1;
        #1 check_reset_state("rst_req");
        @(negedge clk_i);
        rst_i = 1'b0;
        step(O, O, O, O, 32'h0, O, 32'h0);
        check("postA req", {31'd0, bus.imem_req_o}, 32'd1);
        check("postA addr", bus.imem_addr_o, 32'h0);

        // Reset asserted in HOLD; the buffered word must never appear afterwards.
        step(O, O, O, O, 32'h0, I, 32'hCC);
        check("preB if_ir", if_ir_o, 32'hCC);
        step(I, O, O, O, 32'h0, I, 32'hDD);
        check("preB hold req", {31'd0, bus.imem_req_o}, 32'd0);
        check("preB hold addr", bus.imem_addr_o, 32'h4);
        #2 rst_i = 1'b1;
        #1 check_reset_state("rst_hold");
        @(negedge clk_i);
        rst_i = 1'b0;
        step(I, O, O, O, 32'h0, O, 32'h0);
        check("postB idle req", {31'd0, bus.imem_req_o}, 32'd0);
        step(O, O, O, O, 32'h0, O, 32'h0);
        check("postB req", {31'd0, bus.imem_req_o}, 32'd1);
        check("postB addr", bus.imem_addr_o, 32'h0);
        step(O, O, O, O, 32'h0, I, 32'hEE);
        check("postB if_ir", if_ir_o, 32'hEE);
        check("postB if_pc", if_pc_o, 32'h0);
        check("postB next addr", bus.imem_addr_o, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
